// File: rtl/tdm_pkg.sv
// Shared types for the TDM lane demultiplexer: lane count, slot index and frame-alignment states.
package tdm_pkg;

  localparam int unsigned LANES = 4;

  typedef logic [$clog2(LANES)-1:0] slot_t;

  typedef enum logic {
    Hunt,
    Locked
  } state_e;

endpackage

// File: rtl/tdm_demux_if.sv
// Serial beat input and decoded frame output bundle for tdm_demux.
interface tdm_demux_if #(
  parameter int unsigned WIDTH = 2
);

  logic             in_valid;
  logic             in_sync;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic [WIDTH-1:0] out3;
  logic             frame_valid;
  logic             locked;
  logic             sync_err;

  modport master (
    output in_valid, in_sync, in_data,
    input  out0, out1, out2, out3, frame_valid, locked, sync_err
  );

  modport slave (
    input  in_valid, in_sync, in_data,
    output out0, out1, out2, out3, frame_valid, locked, sync_err
  );

endinterface

// File: rtl/sat_cnt8.sv
// 8-bit up counter that sticks at 255; synchronous active-high reset.
module sat_cnt8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  output logic [7:0] count
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else if (inc && (cnt_q != 8'hff)) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/tdm_demux.sv
// 1:4 TDM lane demultiplexer: aligns on in_sync and publishes whole frames only.
// Define TDM_DEMUX_ERRCNT_EN to add the saturating err_cnt output.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH = 2
) (
  input  logic        clk,
  input  logic        reset,
`ifdef TDM_DEMUX_ERRCNT_EN
  output logic [7:0]  err_cnt,
`endif
  tdm_demux_if.slave  bus
);

  state_e           state_q, state_d;
  slot_t            slot_q, slot_d;
  logic [WIDTH-1:0] shadow_q [LANES-1];
  logic [WIDTH-1:0] shadow_d [LANES-1];
  logic [WIDTH-1:0] out_q [LANES];
  logic [WIDTH-1:0] out_d [LANES];
  logic             fv_q, fv_d;
  logic             serr_q, serr_d;

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    shadow_d = shadow_q;
    out_d    = out_q;
    fv_d     = 1'b0;
    serr_d   = 1'b0;
    if (bus.in_valid) begin
      unique case (state_q)
        Hunt: begin
          if (bus.in_sync) begin
            shadow_d[0] = bus.in_data;
            slot_d      = slot_t'(1);
            state_d     = Locked;
          end
        end
        Locked: begin
          if (bus.in_sync && (slot_q != slot_t'(0))) begin
            // Misplaced sync restarts the frame here; the partial frame is dropped.
            serr_d      = 1'b1;
            shadow_d[0] = bus.in_data;
            slot_d      = slot_t'(1);
          end else if (slot_q == slot_t'(LANES - 1)) begin
            out_d[0] = shadow_q[0];
            out_d[1] = shadow_q[1];
            out_d[2] = shadow_q[2];
            out_d[3] = bus.in_data;
            fv_d     = 1'b1;
            slot_d   = slot_t'(0);
          end else begin
            shadow_d[slot_q] = bus.in_data;
            slot_d           = slot_q + slot_t'(1);
          end
        end
        default: state_d = Hunt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= Hunt;
      slot_q  <= slot_t'(0);
      for (int i = 0; i < LANES - 1; i++) shadow_q[i] <= '0;
      for (int i = 0; i < LANES; i++) out_q[i] <= '0;
      fv_q    <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
      fv_q     <= fv_d;
      serr_q   <= serr_d;
    end
  end

  assign bus.out0        = out_q[0];
  assign bus.out1        = out_q[1];
  assign bus.out2        = out_q[2];
  assign bus.out3        = out_q[3];
  assign bus.frame_valid = fv_q;
  assign bus.sync_err    = serr_q;
  assign bus.locked      = (state_q == Locked);

`ifdef TDM_DEMUX_ERRCNT_EN
  sat_cnt8 u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (serr_q),
    .count (err_cnt)
  );
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: directed frames plus random beats against a queue model.
module tb_tdm_demux;

  localparam int unsigned WIDTH = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
`ifdef TDM_DEMUX_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  tdm_demux_if #(.WIDTH(WIDTH)) bus ();

  tdm_demux #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
`ifdef TDM_DEMUX_ERRCNT_EN
    .err_cnt (err_cnt),
`endif
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: the frame under construction is a queue of samples since the last accepted sync.
  int  cur[$];
  bit  m_locked = 1'b0;
  int  exp_out[4] = '{0, 0, 0, 0};
  bit  exp_fv = 1'b0;
  bit  exp_serr = 1'b0;
  int  exp_cnt = 0;
  bit  chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_locked = 1'b0;
      cur.delete();
      exp_out  = '{0, 0, 0, 0};
      exp_fv   = 1'b0;
      exp_serr = 1'b0;
      exp_cnt  = 0;
    end else begin
      if (exp_serr && exp_cnt < 255) exp_cnt++;
      exp_fv   = 1'b0;
      exp_serr = 1'b0;
      if (bus.in_valid) begin
        if (bus.in_sync) begin
          if (m_locked && cur.size() != 0) exp_serr = 1'b1;
          cur.delete();
          cur.push_back(int'(bus.in_data));
          m_locked = 1'b1;
        end else if (m_locked) begin
          cur.push_back(int'(bus.in_data));
        end
        if (cur.size() == 4) begin
          for (int i = 0; i < 4; i++) exp_out[i] = cur[i];
          exp_fv = 1'b1;
          cur.delete();
        end
      end
    end
    chk_en = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("frame_valid", 32'(bus.frame_valid), 32'(exp_fv));
      chk("sync_err", 32'(bus.sync_err), 32'(exp_serr));
      chk("locked", 32'(bus.locked), 32'(m_locked));
      chk("out0", 32'(bus.out0), 32'(exp_out[0]));
      chk("out1", 32'(bus.out1), 32'(exp_out[1]));
      chk("out2", 32'(bus.out2), 32'(exp_out[2]));
      chk("out3", 32'(bus.out3), 32'(exp_out[3]));
`ifdef TDM_DEMUX_ERRCNT_EN
      chk("err_cnt", 32'(err_cnt), 32'(exp_cnt));
`endif
    end
  end

  task automatic beat(input bit v, input bit s, input int d);
    logic [31:0] dv;
    dv = d;
    @(posedge clk);
    #1;
    reset        = 1'b0;
    bus.in_valid = v;
    bus.in_sync  = s;
    bus.in_data  = dv[WIDTH-1:0];
  endtask

  task automatic rst_beat(input bit v, input bit s, input int d);
    beat(v, s, d);
    reset = 1'b1;
  endtask

  task automatic frame_lits(input string tag, input int a, input int b, input int c,
                            input int d);
    chk({tag, "_fv"}, 32'(bus.frame_valid), 32'd1);
    chk({tag, "_out0"}, 32'(bus.out0), 32'(a));
    chk({tag, "_out1"}, 32'(bus.out1), 32'(b));
    chk({tag, "_out2"}, 32'(bus.out2), 32'(c));
    chk({tag, "_out3"}, 32'(bus.out3), 32'(d));
  endtask

  initial begin
    int k;
    bus.in_valid = 1'b0;
    bus.in_sync  = 1'b0;
    bus.in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", 32'(bus.locked), 32'd0);
    chk("rst_out0", 32'(bus.out0), 32'd0);
    chk("rst_fv", 32'(bus.frame_valid), 32'd0);

    // Basic frame 1,2,3,0.
    beat(1, 1, 1); beat(1, 0, 2); beat(1, 0, 3); beat(1, 0, 0);
    beat(0, 0, 0);
    frame_lits("basic", 1, 2, 3, 0);
    chk("basic_locked", 32'(bus.locked), 32'd1);

    // Misplaced sync at slot 2.
    beat(1, 1, 1); beat(1, 0, 2); beat(1, 1, 3);
    beat(0, 0, 0);
    chk("missync_err", 32'(bus.sync_err), 32'd1);
    chk("missync_fv", 32'(bus.frame_valid), 32'd0);
    beat(1, 0, 1); beat(1, 0, 2); beat(1, 0, 0);
    beat(0, 0, 0);
    frame_lits("missync", 3, 1, 2, 0);
    chk("missync_err_clr", 32'(bus.sync_err), 32'd0);

    // Reset mid-frame, with a valid beat present during reset.
    beat(1, 1, 2); beat(1, 0, 1); rst_beat(1, 0, 3);
    beat(0, 0, 0);
    chk("midrst_locked", 32'(bus.locked), 32'd0);
    chk("midrst_out0", 32'(bus.out0), 32'd0);
    chk("midrst_fv", 32'(bus.frame_valid), 32'd0);
    beat(1, 1, 3); beat(1, 0, 2); beat(1, 0, 1); beat(1, 0, 0);
    beat(0, 0, 0);
    frame_lits("postrst", 3, 2, 1, 0);

    // Beats without sync after reset stay hunting.
    rst_beat(0, 0, 0);
    beat(1, 0, 1); beat(1, 0, 2); beat(1, 0, 3);
    beat(0, 0, 0);
    chk("nosync_locked", 32'(bus.locked), 32'd0);
    chk("nosync_out1", 32'(bus.out1), 32'd0);

    // Gapped frame with random junk on idle cycles.
    beat(1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(1, 3)) beat(0, 1'($urandom), int'($urandom));
      beat(1, 0, (i + 2) % 4);
    end
    beat(0, 0, 0);
    frame_lits("gap", 1, 2, 3, 0);
    beat(0, 0, 0);
    chk("gap_fv_once", 32'(bus.frame_valid), 32'd0);

    // Random traffic: mostly well-placed syncs with occasional misplaced or missing ones.
    k = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 65) begin
        beat(1, ((k % 4) == 0) ^ ($urandom_range(0, 15) == 0), int'($urandom));
        k++;
      end else if ($urandom_range(0, 199) == 0) begin
        rst_beat(1, 1'($urandom), int'($urandom));
      end else begin
        beat(0, 1'($urandom), int'($urandom));
      end
    end

`ifdef TDM_DEMUX_ERRCNT_EN
    rst_beat(0, 0, 0);
    beat(1, 1, 0);
    for (int i = 0; i < 300; i++) begin
      beat(1, 0, 0);
      beat(1, 1, 0);
    end
    beat(0, 0, 0);
    beat(0, 0, 0);
    chk("errcnt_sat", 32'(err_cnt), 32'd255);
    rst_beat(0, 0, 0);
    beat(0, 0, 0);
    chk("errcnt_rst", 32'(err_cnt), 32'd0);
`endif

    beat(0, 0, 0);
    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
